// File: rtl/tdm_demux4.sv
// 4-slot TDM receive demux: rebuilds y from 4 accepted strobes; FRAME_ERR_EN adds an err pulse.
// Latency 1 clk from the slot-3 strobe to y/valid; no backpressure, en=0 freezes all state.
`timescale 1ns/1ps
module tdm_demux4 #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       sync,
  input  logic       en,
  output logic [3:0] y,
  output logic [1:0] c,
  output logic       valid
`ifdef FRAME_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [2:0] shadow;
  logic [3:0] frame_word;
  logic [3:0] frame_mapped;

  // frame_word[k] holds slot k; the final slot is taken straight from din
  assign frame_word   = {din, shadow};
  assign frame_mapped = (LSB_FIRST != 0) ? frame_word
                      : {frame_word[0], frame_word[1], frame_word[2], frame_word[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      c      <= 2'd0;
      y      <= 4'b0000;
      valid  <= 1'b0;
      shadow <= 3'b000;
`ifdef FRAME_ERR_EN
      err    <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef FRAME_ERR_EN
      err   <= 1'b0;
`endif
      if (en) begin
        case (state)
          IDLE: begin
            if (sync) begin
              shadow[0] <= din;
              c         <= 2'd1;
              state     <= RUN;
            end
          end
          RUN: begin
            if (c == 2'd0) begin
`ifdef FRAME_ERR_EN
              if (sync) begin
                shadow[0] <= din;
                c         <= 2'd1;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
`else
              shadow[0] <= din;
              c         <= 2'd1;
`endif
            end else if (sync) begin
              // mid-frame sync: drop the partial frame and restart on this bit
              shadow[0] <= din;
              c         <= 2'd1;
`ifdef FRAME_ERR_EN
              err       <= 1'b1;
`endif
            end else if (c == 2'd3) begin
              y     <= frame_mapped;
              valid <= 1'b1;
              c     <= 2'd0;
            end else begin
              shadow[c] <= din;
              c         <= c + 2'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed vector table, a 16-word stream, then random traffic vs a queue model.
`timescale 1ns/1ps
module tb_tdm_demux4;

`ifdef FRAME_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, din, sync, en;
  logic [3:0] y, y_msb;
  logic [1:0] c, c_msb;
  logic       valid, valid_msb;
`ifdef FRAME_ERR_EN
  logic       err, err_msb;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.LSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .din(din), .sync(sync), .en(en),
    .y(y), .c(c), .valid(valid)
`ifdef FRAME_ERR_EN
    , .err(err)
`endif
  );

  tdm_demux4 #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(reset), .din(din), .sync(sync), .en(en),
    .y(y_msb), .c(c_msb), .valid(valid_msb)
`ifdef FRAME_ERR_EN
    , .err(err_msb)
`endif
  );

  typedef struct {
    bit         rst, e, s, d;
    logic [3:0] y;
    logic [1:0] c;
    bit         v, err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: bits collected since alignment, word assembled when 4 are held
  bit         m_aligned;
  bit         m_q[$];
  logic [3:0] m_y;
  bit         m_valid, m_err;

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic model_update(input bit r, input bit e, input bit s, input bit d);
    logic [3:0] word;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_aligned = 1'b0;
      m_q.delete();
      m_y = 4'b0000;
    end else if (e) begin
      if (!m_aligned) begin
        if (s) begin
          m_aligned = 1'b1;
          m_q = {d};
        end
      end else if (m_q.size() == 0) begin
        if (s || !ERR_ON) m_q = {d};
        else begin
          m_err = 1'b1;
          m_aligned = 1'b0;
        end
      end else if (s) begin
        m_q = {d};
        m_err = ERR_ON;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          word = 4'b0000;
          for (int k = 0; k < 4; k++) word = word | (4'(m_q[k]) << k);
          m_y = word;
          m_valid = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit d);
    reset = r; en = e; sync = s; din = d;
    @(posedge clk);
    model_update(r, e, s, d);
    #1;
  endtask

  task automatic add(input bit r, input bit e, input bit s, input bit d,
                     input logic [3:0] ey, input logic [1:0] ec, input bit ev, input bit ee);
    vec_t v;
    v.rst = r; v.e = e; v.s = s; v.d = d;
    v.y = ey; v.c = ec; v.v = ev; v.err = ee;
    tbl.push_back(v);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_y"}, y, m_y);
    chk({tag, "_c"}, 4'(c), 4'(m_q.size()));
    chk({tag, "_valid"}, 4'(valid), 4'(m_valid));
    chk({tag, "_y_msb"}, y_msb, rev4(m_y));
`ifdef FRAME_ERR_EN
    chk({tag, "_err"}, 4'(err), 4'(m_err));
`endif
  endtask

  initial begin
    logic [3:0] wv;

    // reset state
    add(1,0,0,0, 4'b0000, 2'd0, 0, 0);
    // frame 1,0,1,1 -> 1101
    add(0,1,1,1, 4'b0000, 2'd1, 0, 0);
    add(0,1,0,0, 4'b0000, 2'd2, 0, 0);
    add(0,1,0,1, 4'b0000, 2'd3, 0, 0);
    add(0,1,0,1, 4'b1101, 2'd0, 1, 0);
    add(0,0,0,0, 4'b1101, 2'd0, 0, 0);
    // frame 0110 with en toggling; en=0 cycles carry junk din/sync
    add(0,1,1,0, 4'b1101, 2'd1, 0, 0);
    add(0,0,0,1, 4'b1101, 2'd1, 0, 0);
    add(0,1,0,1, 4'b1101, 2'd2, 0, 0);
    add(0,0,1,0, 4'b1101, 2'd2, 0, 0);
    add(0,1,0,1, 4'b1101, 2'd3, 0, 0);
    add(0,0,0,1, 4'b1101, 2'd3, 0, 0);
    add(0,1,0,0, 4'b0110, 2'd0, 1, 0);
    add(0,0,0,0, 4'b0110, 2'd0, 0, 0);
    // broken frame resynced at slot 2, then frame 1010
    add(0,1,1,1, 4'b0110, 2'd1, 0, 0);
    add(0,1,0,1, 4'b0110, 2'd2, 0, 0);
    add(0,1,1,0, 4'b0110, 2'd1, 0, ERR_ON);
    add(0,1,0,1, 4'b0110, 2'd2, 0, 0);
    add(0,1,0,0, 4'b0110, 2'd3, 0, 0);
    add(0,1,0,1, 4'b1010, 2'd0, 1, 0);
    // reset at c=2 with en/sync high, then sync=0 strobes ignored
    add(0,1,1,1, 4'b1010, 2'd1, 0, 0);
    add(0,1,0,1, 4'b1010, 2'd2, 0, 0);
    add(1,1,1,1, 4'b0000, 2'd0, 0, 0);
    add(0,1,0,1, 4'b0000, 2'd0, 0, 0);
    add(0,1,0,1, 4'b0000, 2'd0, 0, 0);
    // frame 0011, then a strobe missing sync
    add(0,1,1,1, 4'b0000, 2'd1, 0, 0);
    add(0,1,0,1, 4'b0000, 2'd2, 0, 0);
    add(0,1,0,0, 4'b0000, 2'd3, 0, 0);
    add(0,1,0,0, 4'b0011, 2'd0, 1, 0);
    add(0,1,0,1, 4'b0011, ERR_ON ? 2'd0 : 2'd1, 0, ERR_ON);
    add(0,1,0,1, 4'b0011, ERR_ON ? 2'd0 : 2'd2, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].e, tbl[i].s, tbl[i].d);
      chk($sformatf("tbl%0d_y", i), y, tbl[i].y);
      chk($sformatf("tbl%0d_c", i), 4'(c), 4'(tbl[i].c));
      chk($sformatf("tbl%0d_valid", i), 4'(valid), 4'(tbl[i].v));
      chk($sformatf("tbl%0d_y_msb", i), y_msb, rev4(tbl[i].y));
`ifdef FRAME_ERR_EN
      chk($sformatf("tbl%0d_err", i), 4'(err), 4'(tbl[i].err));
`endif
    end

    // all 16 words back-to-back, sync only on the first frame
    step(1, 0, 0, 0);
    chk("stream_reset_y", y, 4'b0000);
    chk("stream_reset_c", 4'(c), 4'd0);
    for (int w = 0; w < 16; w++) begin
      wv = 4'(w);
      for (int k = 0; k < 4; k++) begin
        step(0, 1, (k == 0) && (w == 0 || ERR_ON), wv[k]);
        chk($sformatf("stream_w%0d_s%0d_valid", w, k), 4'(valid), (k == 3) ? 4'd1 : 4'd0);
        chk($sformatf("stream_w%0d_s%0d_c", w, k), 4'(c), 4'((k + 1) % 4));
        if (k == 3) begin
          chk($sformatf("stream_w%0d_y", w), y, wv);
          chk($sformatf("stream_w%0d_y_msb", w), y_msb, rev4(wv));
        end
      end
    end

    // random traffic against the model
    step(1, 0, 0, 0);
    check_model("rnd_reset");
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0,
           1'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
